seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous, tear-free data update.
// Optional blink logic is compiled in when the macro SEG7_BLINK_EN is defined.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_end,
    output logic                    upd_done
);

    localparam int TW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

    logic [TW-1:0]           timer;
    logic [IW-1:0]           index;
    logic                    slot_end;
    logic [4*NUM_DIGITS-1:0] disp_bcd, pend_bcd;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
    logic                    pend_valid;

    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    above_zero;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    blink_off;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    assign slot_end  = (timer == TIMER_LAST);
    assign frame_end = slot_end && (index == INDEX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            timer <= '0;
            index <= '0;
        end else if (slot_end) begin
            timer <= '0;
            index <= (index == INDEX_LAST) ? '0 : index + 1'b1;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Display data only changes on the frame boundary; a coincident load wins over pending data.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            disp_bcd   <= '0;
            disp_dp    <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            upd_done   <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            if (frame_end && load) begin
                disp_bcd   <= digits_bcd;
                disp_dp    <= dp_in;
                pend_valid <= 1'b0;
                upd_done   <= 1'b1;
            end else if (frame_end && pend_valid) begin
                disp_bcd   <= pend_bcd;
                disp_dp    <= pend_dp;
                pend_valid <= 1'b0;
                upd_done   <= 1'b1;
            end else if (load) begin
                pend_bcd   <= digits_bcd;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_bcd    = '0;
        cur_dp     = 1'b0;
        lz_mask    = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            above_zero = above_zero && (disp_bcd[4*i +: 4] == 4'd0);
            lz_mask[i] = lz_blank && above_zero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IW'(i)) begin
                cur_bcd = disp_bcd[4*i +: 4];
                cur_dp  = disp_dp[i];
            end
        end
        an_next  = ~(NUM_DIGITS'(1) << index);
        seg_next = (|(lz_mask & ~an_next)) ? 7'b1111111 : decode(cur_bcd);
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] frame_cnt;
    logic          blink_on;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_off = !blink_on && (|(blink_mask & ~an_next));
`else
    logic blink_unused;
    assign blink_unused = ^blink_mask;
    assign blink_off    = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            an  <= '1;
        end else if (blink_off) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_next;
            dp  <= ~cur_dp;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=4, NUM_DIGITS=4, BLINK_FRAMES=2.
// Expectations follow the blink setting selected by SEG7_BLINK_EN at compile time.
module tb_seg7_scan_ctrl;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b1;
    logic [15:0] digits_bcd = '0;
    logic [3:0]  dp_in      = '0;
    logic        load       = 1'b0;
    logic        lz_blank   = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_end;
    logic        upd_done;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef SEG7_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .digits_bcd (digits_bcd),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_end  (frame_end),
        .upd_done   (upd_done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // One clock; cyc counts rising edges since the last reset release, sampling on the falling edge.
    task automatic step();
        @(posedge clk_100MHz);
        cyc++;
        @(negedge clk_100MHz);
    endtask

    task automatic advance_to(input int pos);
        for (int i = 0; i < 17 && (cyc % 16) != pos; i++) step();
    endtask

    task automatic test_reset();
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        tests++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        tests++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        tests++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        tests++; if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end got=%b exp=0", frame_end); end
        tests++; if (upd_done !== 1'b0) begin errors++; $display("FAIL reset_upd_done got=%b exp=0", upd_done); end
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_scan();
        int slot;
        int fe_count = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            slot = ((cyc - 1) % 16) / 4;
            tests++; if (an !== ~(4'b0001 << slot)) begin errors++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, ~(4'b0001 << slot)); end
            tests++; if (seg !== 7'b0000001) begin errors++; $display("FAIL scan_seg cyc=%0d got=%b exp=0000001", cyc, seg); end
            tests++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", cyc, dp); end
            tests++; if (frame_end !== ((cyc % 16) == 15)) begin errors++; $display("FAIL scan_frame_end cyc=%0d got=%b", cyc, frame_end); end
            tests++; if (upd_done !== 1'b0) begin errors++; $display("FAIL scan_upd_done cyc=%0d got=%b exp=0", cyc, upd_done); end
            if (frame_end) fe_count++;
        end
        tests++; if (fe_count != 2) begin errors++; $display("FAIL scan_frame_count got=%0d exp=2", fe_count); end
    endtask

    task automatic test_load_midframe();
        int          slot;
        int          apply;
        logic [15:0] val;
        logic [3:0]  dpv;
        advance_to(5);
        digits_bcd = 16'h1234; dp_in = 4'b0010; load = 1'b1;
        step();
        load = 1'b0; digits_bcd = 16'h9999; dp_in = 4'b1111;
        apply = cyc - (cyc % 16) + 16;
        while (cyc < apply + 16) begin
            step();
            slot = ((cyc - 1) % 16) / 4;
            val  = (cyc > apply) ? 16'h1234 : 16'h0000;
            dpv  = (cyc > apply) ? 4'b0010 : 4'b0000;
            tests++; if (seg !== seg_of(val[slot*4 +: 4])) begin errors++; $display("FAIL load_seg cyc=%0d got=%b exp=%b", cyc, seg, seg_of(val[slot*4 +: 4])); end
            tests++; if (dp !== ~dpv[slot]) begin errors++; $display("FAIL load_dp cyc=%0d got=%b exp=%b", cyc, dp, ~dpv[slot]); end
            tests++; if (upd_done !== (cyc == apply)) begin errors++; $display("FAIL load_upd_done cyc=%0d got=%b exp=%b", cyc, upd_done, cyc == apply); end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [3];
        logic [3:0]  dps  [3];
        logic [6:0]  exp_seg [3][4];
        int          slot;
        vals[0] = 16'h0007; dps[0] = 4'b1000;
        vals[1] = 16'h0000; dps[1] = 4'b0000;
        vals[2] = 16'h0705; dps[2] = 4'b0000;
        exp_seg[0] = '{7'b0001111, 7'b1111111, 7'b1111111, 7'b1111111};
        exp_seg[1] = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
        exp_seg[2] = '{7'b0100100, 7'b0000001, 7'b0001111, 7'b1111111};
        lz_blank = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance_to(3);
            digits_bcd = vals[c]; dp_in = dps[c]; load = 1'b1;
            step();
            load = 1'b0;
            advance_to(0);
            for (int k = 0; k < 16; k++) begin
                step();
                slot = ((cyc - 1) % 16) / 4;
                tests++; if (seg !== exp_seg[c][slot]) begin errors++; $display("FAIL lz_seg case=%0d slot=%0d got=%b exp=%b", c, slot, seg, exp_seg[c][slot]); end
                tests++; if (dp !== ~dps[c][slot]) begin errors++; $display("FAIL lz_dp case=%0d slot=%0d got=%b exp=%b", c, slot, dp, ~dps[c][slot]); end
            end
        end
        lz_blank = 1'b0;
        dp_in    = 4'b0000;
    endtask

    task automatic test_back_to_back();
        int          apply;
        int          pulses = 0;
        int          slot;
        logic [15:0] val;
        advance_to(3);
        digits_bcd = 16'h1111; load = 1'b1;
        step();
        load = 1'b0;
        advance_to(8);
        digits_bcd = 16'h2222; load = 1'b1;
        step();
        load = 1'b0;
        apply = cyc - (cyc % 16) + 16;
        while (cyc < apply + 16) begin
            step();
            if (upd_done) pulses++;
            if (cyc > apply) begin
                tests++; if (seg !== 7'b0010010) begin errors++; $display("FAIL b2b_seg cyc=%0d got=%b exp=0010010", cyc, seg); end
            end
        end
        tests++; if (pulses != 1) begin errors++; $display("FAIL b2b_upd_pulses got=%0d exp=1", pulses); end

        advance_to(15);
        tests++; if (frame_end !== 1'b1) begin errors++; $display("FAIL coinc_frame_end got=%b exp=1", frame_end); end
        digits_bcd = 16'h5678; load = 1'b1;
        step();
        load = 1'b0;
        tests++; if (upd_done !== 1'b1) begin errors++; $display("FAIL coinc_upd_done got=%b exp=1", upd_done); end
        tests++; if (seg !== 7'b0010010) begin errors++; $display("FAIL coinc_last_slot_seg got=%b exp=0010010", seg); end
        val = 16'h5678;
        for (int k = 0; k < 16; k++) begin
            step();
            slot = ((cyc - 1) % 16) / 4;
            tests++; if (seg !== seg_of(val[slot*4 +: 4])) begin errors++; $display("FAIL coinc_seg slot=%0d got=%b exp=%b", slot, seg, seg_of(val[slot*4 +: 4])); end
            tests++; if (upd_done !== 1'b0) begin errors++; $display("FAIL coinc_upd_extra cyc=%0d got=%b exp=0", cyc, upd_done); end
        end
    endtask

    task automatic test_blink();
        int          slot;
        int          frame;
        logic        off;
        logic [15:0] val;
        val        = 16'h5678;
        blink_mask = 4'b0001;
        for (int k = 0; k < 64; k++) begin
            step();
            slot  = ((cyc - 1) % 16) / 4;
            frame = (cyc - 1) / 16;
            off   = BLINK_BUILT && ((frame / 2) % 2 == 1) && (slot == 0);
            tests++; if (an !== (off ? 4'b1111 : ~(4'b0001 << slot))) begin errors++; $display("FAIL blink_an cyc=%0d got=%b off=%b", cyc, an, off); end
            tests++; if (seg !== (off ? 7'b1111111 : seg_of(val[slot*4 +: 4]))) begin errors++; $display("FAIL blink_seg cyc=%0d got=%b off=%b", cyc, seg, off); end
            tests++; if (dp !== 1'b1) begin errors++; $display("FAIL blink_dp cyc=%0d got=%b exp=1", cyc, dp); end
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_reset_midframe();
        int slot;
        advance_to(4);
        digits_bcd = 16'h9876; dp_in = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        advance_to(9);
        #2 reset = 1'b1;
        #1;
        tests++; if (seg !== 7'b1111111) begin errors++; $display("FAIL rst_mid_seg got=%b exp=1111111", seg); end
        tests++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_mid_an got=%b exp=1111", an); end
        tests++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_mid_dp got=%b exp=1", dp); end
        tests++; if (frame_end !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_end got=%b exp=0", frame_end); end
        @(negedge clk_100MHz);
        tests++; if (upd_done !== 1'b0) begin errors++; $display("FAIL rst_mid_upd_done got=%b exp=0", upd_done); end
        reset = 1'b0;
        cyc   = 0;
        dp_in = 4'b0000;
        for (int k = 0; k < 32; k++) begin
            step();
            slot = ((cyc - 1) % 16) / 4;
            tests++; if (seg !== 7'b0000001) begin errors++; $display("FAIL rst_mid_after_seg cyc=%0d got=%b exp=0000001", cyc, seg); end
            tests++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_mid_after_dp cyc=%0d got=%b exp=1", cyc, dp); end
            tests++; if (an !== ~(4'b0001 << slot)) begin errors++; $display("FAIL rst_mid_after_an cyc=%0d got=%b", cyc, an); end
            tests++; if (upd_done !== 1'b0) begin errors++; $display("FAIL rst_mid_after_upd cyc=%0d got=%b exp=0", cyc, upd_done); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_lz_blank();
        test_back_to_back();
        test_blink();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
